// File: rtl/contador_bcd_mux.sv
// contador_bcd_mux: multi-digit BCD up/down counter with a time-multiplexed
// digit scanner feeding a 7-segment decoder.
//
// Parameters:
//   DIGITS   - number of BCD digits counted and scanned (1..8)
//   SCAN_DIV - clock cycles each digit stays selected (>= 1)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   en      in   count enable, one count per cycle
//   up      in   direction: 1 = increment, 0 = decrement
//   clr     in   synchronous clear, has priority over en
//   valor   out  full BCD count, digit 0 in bits [3:0]
//   estouro out  one-cycle pulse after a wrap in either direction
//   data    out  BCD code of the selected digit
//   sel     out  one-hot, active-high digit select
//
// Optional build macro: BLANK_ZEROS_EN enables leading-zero blanking on data
// (blanked digits are driven as 4'hF; digit 0 is never blanked).
module contador_bcd_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  output logic [4*DIGITS-1:0] valor,
  output logic                estouro,
  output logic [3:0]          data,
  output logic [DIGITS-1:0]   sel
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [4*DIGITS-1:0] r_valor;
  logic                r_estouro;
  logic [2:0]          r_idx;
  logic [DW-1:0]       r_div;
  logic [DIGITS-1:0]   r_sel;
  logic [3:0]          r_data;

  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;
  logic                w_carry;
  logic                w_borrow;
  logic [3:0]          w_cur;
  logic [3:0]          w_data_next;
  logic                w_div_last;

  // Ripple carry/borrow across digits; a carry (borrow) surviving past the
  // top digit means the whole count wrapped.
  always_comb begin
    w_inc    = r_valor;
    w_dec    = r_valor;
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_valor[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_valor[4*i +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_valor[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_valor[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_cur = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == 3'(i)) begin
        w_cur = r_valor[4*i +: 4];
      end
    end
  end

`ifdef BLANK_ZEROS_EN
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_above;

  // Walk down from the most significant digit; a digit is blank while it and
  // everything above it is zero. Digit 0 is excluded so zero shows as "0".
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      w_zero_above = w_zero_above & (r_valor[4*k +: 4] == 4'd0);
      w_blank[k]   = w_zero_above;
    end
  end

  always_comb begin
    w_data_next = w_cur;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == 3'(i) && w_blank[i]) begin
        w_data_next = 4'hF;
      end
    end
  end
`else
  always_comb begin
    w_data_next = w_cur;
  end
`endif

  assign w_div_last = (r_div == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valor   <= '0;
      r_estouro <= 1'b0;
    end else if (clr) begin
      r_valor   <= '0;
      r_estouro <= 1'b0;
    end else if (en) begin
      r_valor   <= up ? w_inc : w_dec;
      r_estouro <= up ? w_carry : w_borrow;
    end else begin
      r_estouro <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_idx  <= '0;
      r_sel  <= DIGITS'(1);
      r_data <= '0;
    end else begin
      if (w_div_last) begin
        r_div <= '0;
        r_idx <= (r_idx == 3'(DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_div <= r_div + DW'(1);
      end
      r_sel  <= DIGITS'(1) << r_idx;
      r_data <= w_data_next;
    end
  end

  assign valor   = r_valor;
  assign estouro = r_estouro;
  assign data    = r_data;
  assign sel     = r_sel;

endmodule

// File: tb/tb_contador_bcd_mux.sv
module tb_contador_bcd_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 3;
  localparam int MAXV     = 10 ** DIGITS - 1;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic                up;
  logic                clr;
  logic [4*DIGITS-1:0] valor;
  logic                estouro;
  logic [3:0]          data;
  logic [DIGITS-1:0]   sel;

  int n_checks;
  int n_fail;

  // Reference model: count held as a plain integer, scan position derived
  // from the number of edges seen since reset release.
  int                m_val;
  int                m_n;
  logic              m_est;
  logic [DIGITS-1:0] m_sel;
  logic [3:0]        m_data;

  contador_bcd_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .up     (up),
    .clr    (clr),
    .valor  (valor),
    .estouro(estouro),
    .data   (data),
    .sel    (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit expired, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic logic [3:0] model_digit(input int v, input int i);
`ifdef BLANK_ZEROS_EN
    if (i >= 1 && (v / (10 ** i)) == 0) return 4'hF;
`endif
    return 4'((v / (10 ** i)) % 10);
  endfunction

  // Drive one cycle of inputs and advance the model across that edge.
  task automatic step(input logic e, input logic u, input logic c);
    int idx;
    en  = e;
    up  = u;
    clr = c;
    @(posedge clk);
    idx        = (m_n / SCAN_DIV) % DIGITS;
    m_sel      = '0;
    m_sel[idx] = 1'b1;
    m_data     = model_digit(m_val, idx);
    m_est      = 1'b0;
    if (c) begin
      m_val = 0;
    end else if (e) begin
      if (u) begin
        if (m_val == MAXV) begin m_val = 0; m_est = 1'b1; end
        else m_val = m_val + 1;
      end else begin
        if (m_val == 0) begin m_val = MAXV; m_est = 1'b1; end
        else m_val = m_val - 1;
      end
    end
    m_n = m_n + 1;
    #1;
  endtask

  task automatic load(input int v);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < v; k++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    load(123);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    m_val = 0; m_n = 0; m_est = 1'b0;
    n_checks++;
    if (valor !== '0) begin n_fail++; $display("FAIL reset_valor: got %h expected %h", valor, 16'h0); end
    n_checks++;
    if (sel !== 4'b0001) begin n_fail++; $display("FAIL reset_sel: got %b expected %b", sel, 4'b0001); end
    n_checks++;
    if (data !== 4'd0) begin n_fail++; $display("FAIL reset_data: got %h expected %h", data, 4'd0); end
    n_checks++;
    if (estouro !== 1'b0) begin n_fail++; $display("FAIL reset_estouro: got %b expected 0", estouro); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2 * SCAN_DIV; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (sel !== m_sel) begin n_fail++; $display("FAIL reset_resume_sel: got %b expected %b", sel, m_sel); end
      n_checks++;
      if (data !== m_data) begin n_fail++; $display("FAIL reset_resume_data: got %h expected %h", data, m_data); end
    end
  endtask

  task automatic test_inc_carry;
    load(999);
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (valor !== 16'h1000) begin n_fail++; $display("FAIL inc_carry_valor: got %h expected %h", valor, 16'h1000); end
    n_checks++;
    if (estouro !== 1'b0) begin n_fail++; $display("FAIL inc_carry_estouro: got %b expected 0", estouro); end
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (valor !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap_valor: got %h expected %h", valor, 16'h0); end
    n_checks++;
    if (estouro !== 1'b1) begin n_fail++; $display("FAIL inc_wrap_estouro: got %b expected 1", estouro); end
    step(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (valor !== 16'h0001) begin n_fail++; $display("FAIL inc_after_wrap_valor: got %h expected %h", valor, 16'h1); end
    n_checks++;
    if (estouro !== 1'b0) begin n_fail++; $display("FAIL inc_single_pulse: got %b expected 0", estouro); end
  endtask

  task automatic test_dec_borrow;
    load(1000);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (valor !== 16'h0999) begin n_fail++; $display("FAIL dec_borrow_valor: got %h expected %h", valor, 16'h0999); end
    n_checks++;
    if (estouro !== 1'b0) begin n_fail++; $display("FAIL dec_borrow_estouro: got %b expected 0", estouro); end
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (valor !== 16'h9999) begin n_fail++; $display("FAIL dec_wrap_valor: got %h expected %h", valor, 16'h9999); end
    n_checks++;
    if (estouro !== 1'b1) begin n_fail++; $display("FAIL dec_wrap_estouro: got %b expected 1", estouro); end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (valor !== 16'h9998) begin n_fail++; $display("FAIL dec_after_wrap_valor: got %h expected %h", valor, 16'h9998); end
    n_checks++;
    if (estouro !== 1'b0) begin n_fail++; $display("FAIL dec_single_pulse: got %b expected 0", estouro); end
  endtask

  task automatic test_priority;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (valor !== 16'h0000) begin n_fail++; $display("FAIL prio_valor: got %h expected %h", valor, 16'h0); end
    n_checks++;
    if (estouro !== 1'b0) begin n_fail++; $display("FAIL prio_estouro: got %b expected 0", estouro); end
  endtask

  task automatic test_scan(input int v);
    load(v);
    for (int k = 0; k < 5 * SCAN_DIV * DIGITS; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (sel !== m_sel) begin n_fail++; $display("FAIL scan_sel(v=%0d): got %b expected %b", v, sel, m_sel); end
      n_checks++;
      if (data !== m_data) begin n_fail++; $display("FAIL scan_data(v=%0d): got %h expected %h", v, data, m_data); end
      n_checks++;
      if (valor !== to_bcd(m_val)) begin n_fail++; $display("FAIL scan_valor: got %h expected %h", valor, to_bcd(m_val)); end
    end
  endtask

  task automatic test_random;
    logic e, u, c;
    load($urandom_range(0, MAXV));
    for (int k = 0; k < 600; k++) begin
      c = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) == 1;
      if (k % 97 == 5) begin c = 1'b0; e = 1'b1; u = 1'b0; m_val = m_val; end
      step(e, u, c);
      n_checks++;
      if (valor !== to_bcd(m_val)) begin n_fail++; $display("FAIL rand_valor: got %h expected %h", valor, to_bcd(m_val)); end
      n_checks++;
      if (estouro !== m_est) begin n_fail++; $display("FAIL rand_estouro: got %b expected %b", estouro, m_est); end
      n_checks++;
      if (sel !== m_sel) begin n_fail++; $display("FAIL rand_sel: got %b expected %b", sel, m_sel); end
      n_checks++;
      if (data !== m_data) begin n_fail++; $display("FAIL rand_data: got %h expected %h", data, m_data); end
    end
  endtask

  task automatic test_back_to_back;
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3 * (MAXV + 1) / 1000 + 25; k++) begin
      step(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (valor !== to_bcd(m_val)) begin n_fail++; $display("FAIL b2b_valor: got %h expected %h", valor, to_bcd(m_val)); end
      n_checks++;
      if (estouro !== m_est) begin n_fail++; $display("FAIL b2b_estouro: got %b expected %b", estouro, m_est); end
      n_checks++;
      if (data !== m_data) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", data, m_data); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_val    = 0;
    m_n      = 0;
    m_est    = 1'b0;
    m_sel    = '0;
    m_data   = '0;
    en       = 1'b0;
    up       = 1'b0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    test_reset;
    test_inc_carry;
    test_dec_borrow;
    test_priority;
    test_scan(4321);
    test_scan(50);
    test_scan(0);
    test_random;
    test_back_to_back;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
